fifo_wr_arbiter: RTL

FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

---
 rtl/fifo_wr_arbiter.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin arbiter for N_REQ writers sharing one FIFO write port.
// Grant, write enable and write data are combinational (zero-cycle request-to-write).
// Build option FIFO_ARB_BURST_EN: a winner keeps the port for up to BURST_LEN words.
// N_REQ must be at least 2.
//
// state | meaning (burst build only)
// IDLE  | arbitrate among all requesters every cycle
// OWN   | burst owner holds the port until BURST_LEN words, a request drop, or reset
module fifo_wr_arbiter #(
  parameter int N_REQ      = 4,
  parameter int DATA_WIDTH = 8,
  parameter int BURST_LEN  = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [N_REQ-1:0]            req,
  input  logic [N_REQ*DATA_WIDTH-1:0] data_in,
  input  logic                        fifo_full,
  output logic [N_REQ-1:0]            gnt,
  output logic                        fifo_wr_en,
  output logic [DATA_WIDTH-1:0]       fifo_wdata,
  output logic                        owner_vld,
  output logic [$clog2(N_REQ)-1:0]    owner_id,
  output logic [15:0]                 word_cnt
);
  localparam int IDW = $clog2(N_REQ);

  if (BURST_LEN < 1) begin : g_burst_len_chk
    $error("fifo_wr_arbiter: BURST_LEN must be at least 1");
  end

  logic [IDW-1:0]        ptr_q, ptr_d;
  logic [15:0]           word_cnt_q, word_cnt_d;
  logic                  win_vld;
  logic [IDW-1:0]        win_idx;
  logic [N_REQ-1:0]      gnt_c;
  logic                  take_win;
  logic                  owner_vld_c;
  logic [IDW-1:0]        owner_id_c;
  logic [DATA_WIDTH-1:0] wdata_c;

  // Round-robin search: first requester at or after ptr, wrapping modulo N_REQ
  always_comb begin
    win_vld = 1'b0;
    win_idx = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (!win_vld && req[(int'(ptr_q) + i) % N_REQ]) begin
        win_vld = 1'b1;
        win_idx = IDW'((int'(ptr_q) + i) % N_REQ);
      end
    end
  end

`ifdef FIFO_ARB_BURST_EN
  localparam int CW = $clog2(BURST_LEN + 1);
  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_OWN  = 1'b1;

  logic [0:0]     state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [IDW-1:0] owner_q, owner_d;

  // Burst FSM: grant selection and next-state for IDLE/OWN
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    owner_d     = owner_q;
    gnt_c       = '0;
    take_win    = 1'b0;
    owner_vld_c = 1'b0;
    owner_id_c  = '0;
    case (state_q)
      ST_OWN: begin
        owner_vld_c = 1'b1;
        owner_id_c  = owner_q;
        if (!fifo_full) begin
          if (req[owner_q]) begin
            gnt_c[owner_q] = 1'b1;
            if (cnt_q + CW'(1) == CW'(BURST_LEN)) begin
              state_d = ST_IDLE;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_q + CW'(1);
            end
          end else begin
            // owner went away: give up the port, one idle cycle
            state_d = ST_IDLE;
            cnt_d   = '0;
          end
        end
      end
      default: begin
        if (!fifo_full && win_vld) begin
          gnt_c[win_idx] = 1'b1;
          take_win       = 1'b1;
          if (BURST_LEN > 1) begin
            // the winning cycle already counts as the owner's first word
            state_d     = ST_OWN;
            owner_d     = win_idx;
            cnt_d       = CW'(1);
            owner_vld_c = 1'b1;
            owner_id_c  = win_idx;
          end
        end
      end
    endcase
  end

  // Burst FSM registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      owner_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      owner_q <= owner_d;
    end
  end
`else
  // Plain round-robin: every transfer is a fresh arbitration
  always_comb begin
    gnt_c    = '0;
    take_win = 1'b0;
    if (!fifo_full && win_vld) begin
      gnt_c[win_idx] = 1'b1;
      take_win       = 1'b1;
    end
  end

  assign owner_vld_c = 1'b0;
  assign owner_id_c  = '0;
`endif

  // Write-data mux over the (one-hot) grant
  always_comb begin
    wdata_c = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (gnt[i]) wdata_c = wdata_c | data_in[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  // Pointer advance and saturating write counter
  always_comb begin
    ptr_d = ptr_q;
    if (take_win) ptr_d = (win_idx == IDW'(N_REQ - 1)) ? '0 : win_idx + IDW'(1);
    word_cnt_d = word_cnt_q;
    if (fifo_wr_en && word_cnt_q != 16'hFFFF) word_cnt_d = word_cnt_q + 16'd1;
  end

  // Shared registers
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q      <= '0;
      word_cnt_q <= '0;
    end else begin
      ptr_q      <= ptr_d;
      word_cnt_q <= word_cnt_d;
    end
  end

  assign gnt        = rst ? '0 : gnt_c;
  assign fifo_wr_en = |gnt;
  assign fifo_wdata = wdata_c;
  assign owner_vld  = !rst && owner_vld_c;
  assign owner_id   = owner_vld ? owner_id_c : '0;
  assign word_cnt   = word_cnt_q;
endmodule
